// File: rtl/fp16_pkg.sv
// Shared constants and FSM state encoding for the sequential fp16 add/subtract stage.
package fp16_pkg;
  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] ZERO_P = 16'h0000;
  localparam logic [15:0] INF    = 16'h7C00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;
endpackage

// File: rtl/fp16_norm_step.sv
// One normalisation step: a single right or left shift of the sum per call.
// Purely combinational; the FSM iterates it once per NORM cycle.
module fp16_norm_step #(
  parameter int EXP_W = fp16_pkg::EXP_W,
  parameter int MAN_W = fp16_pkg::MAN_W
) (
  input  logic [MAN_W+1:0] sum_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [MAN_W+1:0] sum_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             finished,
  output logic             ovf,
  output logic             unf
);
  import fp16_pkg::*;

  always_comb begin
    sum_o    = sum_i;
    exp_o    = exp_i;
    finished = 1'b0;
    ovf      = 1'b0;
    unf      = 1'b0;
    if (sum_i == '0) begin
      finished = 1'b1;
    end else if (sum_i[MAN_W+1]) begin
      // carry-out: after one right shift the hidden bit is in place
      sum_o    = sum_i >> 1;
      exp_o    = exp_i + 1'b1;
      finished = 1'b1;
      ovf      = (exp_o == EXP_W'(EXP_MAX));
    end else if (sum_i[MAN_W]) begin
      finished = 1'b1;
    end else begin
      sum_o = sum_i << 1;
      exp_o = exp_i - 1'b1;
      if (exp_o == '0) begin
        finished = 1'b1;
        unf      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp16_addsub_seq.sv
// Multi-cycle fp16 add/subtract: swap, 1-bit/cycle align, add, iterative normalise, repack.
// Zero and equal-operand shortcuts finish one cycle after start; no rounding (truncation).
module fp16_addsub_seq #(
  parameter int EXP_W     = fp16_pkg::EXP_W,
  parameter int MAN_W     = fp16_pkg::MAN_W,
  parameter int ALIGN_CAP = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic                   s1,
  input  logic                   s2,
  input  logic [EXP_W-1:0]       e1,
  input  logic [EXP_W-1:0]       e2,
  input  logic [MAN_W:0]         m1,
  input  logic [MAN_W:0]         m2,
  input  logic                   if_equal,
  input  logic [1:0]             if_zero,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   unf
);
  import fp16_pkg::*;

  state_t                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic                   eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0]       exp_q, exp_d;
  logic [EXP_W-1:0]       diff_q, diff_d;
  logic [MAN_W:0]         ma_q, ma_d;
  logic [MAN_W:0]         mb_q, mb_d;
  logic [MAN_W+1:0]       sum_q, sum_d;
  logic [EXP_W+MAN_W:0]   result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic                   sb;
  logic                   b_gt;
  logic [EXP_W-1:0]       diff_raw;
  logic [MAN_W+1:0]       n_sum;
  logic [EXP_W-1:0]       n_exp;
  logic                   n_fin, n_ovf, n_unf;

  assign sb   = s2 ^ op;
  assign b_gt = {e2, m2[MAN_W-1:0]} > {e1, m1[MAN_W-1:0]};

  fp16_norm_step #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm (
    .sum_i    (sum_q),
    .exp_i    (exp_q),
    .sum_o    (n_sum),
    .exp_o    (n_exp),
    .finished (n_fin),
    .ovf      (n_ovf),
    .unf      (n_unf)
  );

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    sum_d     = sum_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    diff_raw  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (op && if_equal) begin
            result_d = ZERO_P;
            state_d  = S_DONE;
          end else if (if_zero == 2'b11) begin
            result_d = {s1 & sb, {(EXP_W+MAN_W){1'b0}}};
            state_d  = S_DONE;
          end else if (if_zero[0]) begin
            result_d = {sb, e2, m2[MAN_W-1:0]};
            state_d  = S_DONE;
          end else if (if_zero[1]) begin
            result_d = {s1, e1, m1[MAN_W-1:0]};
            state_d  = S_DONE;
          end else begin
            // operand A always carries the larger magnitude so the subtract never goes negative
            if (b_gt) begin
              ma_d     = m2;
              mb_d     = m1;
              exp_d    = e2;
              sign_d   = sb;
              diff_raw = e2 - e1;
            end else begin
              ma_d     = m1;
              mb_d     = m2;
              exp_d    = e1;
              sign_d   = s1;
              diff_raw = e1 - e2;
            end
            eff_sub_d = s1 ^ sb;
            if (diff_raw >= EXP_W'(ALIGN_CAP)) begin
              mb_d   = '0;
              diff_d = '0;
            end else begin
              diff_d = diff_raw;
            end
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        if (diff_q == '0) begin
          state_d = S_ADD;
        end else begin
          mb_d   = mb_q >> 1;
          diff_d = diff_q - 1'b1;
        end
      end
      S_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                            : ({1'b0, ma_q} + {1'b0, mb_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        sum_d = n_sum;
        exp_d = n_exp;
        if (n_fin) begin
          ovf_d   = n_ovf;
          unf_d   = n_unf;
          state_d = S_DONE;
          if (n_unf || (n_sum == '0)) begin
            result_d = ZERO_P;
          end else if (n_ovf) begin
            result_d = INF | {sign_q, {(EXP_W+MAN_W){1'b0}}};
          end else begin
            result_d = {sign_q, n_exp, n_sum[MAN_W-1:0]};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      diff_q    <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      sum_q     <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      diff_q    <= diff_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
endmodule

// File: tb/tb_fp16_addsub_seq.sv
// Directed vectors for fp16_addsub_seq: results, flags, latency, busy, reset abort and ignored start.
module tb_fp16_addsub_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic        s1, s2;
  logic [4:0]  e1, e2;
  logic [10:0] m1, m2;
  logic        if_equal;
  logic [1:0]  if_zero;
  logic        busy, done, ovf, unf;
  logic [15:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] prev_res;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  fp16_addsub_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .s1       (s1),
    .s2       (s2),
    .e1       (e1),
    .e2       (e2),
    .m1       (m1),
    .m2       (m2),
    .if_equal (if_equal),
    .if_zero  (if_zero),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic o,
                              input logic [15:0] r, input logic ov, input logic un, input int l);
    vec_t v;
    v.a = a; v.b = b; v.op = o; v.res = r; v.ovf = ov; v.unf = un; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input int got_v, input int exp_v);
    checks++;
    if (got_v != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got_v, exp_v);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic o);
    op       = o;
    s1       = a[15];
    e1       = a[14:10];
    m1       = {1'b1, a[9:0]};
    s2       = b[15];
    e2       = b[14:10];
    m2       = {1'b1, b[9:0]};
    if_equal = (a == b);
    if_zero  = {b[14:0] == 15'd0, a[14:0] == 15'd0};
  endtask

  task automatic run_op(input vec_t v, input string tag);
    bit got;
    bit busy_bad;
    int lat;
    @(negedge clk);
    drive(v.a, v.b, v.op);
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    got      = 1'b0;
    busy_bad = 1'b0;
    lat      = 0;
    if (v.lat > 1) begin
      check({tag, "_held_result"}, result, prev_res);
      check({tag, "_flags_cleared"}, {ovf, unf}, 0);
    end
    for (int c = 1; c <= 64; c++) begin
      if (!busy) busy_bad = 1'b1;
      if (done) begin
        got = 1'b1;
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_result"}, result, v.res);
    check({tag, "_ovf"}, ovf, v.ovf);
    check({tag, "_unf"}, unf, v.unf);
    check({tag, "_busy_gap"}, busy_bad, 0);
    prev_res = v.res;
    @(posedge clk); #1;
    check({tag, "_back_idle"}, {busy, done}, 0);
  endtask

  initial begin
    int pulses;
    bit got;
    int lat;

    vt[0]  = mk(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 4);
    vt[1]  = mk(16'h3C00, 16'h3800, 1'b0, 16'h3E00, 1'b0, 1'b0, 5);
    vt[2]  = mk(16'h3C00, 16'h3A00, 1'b1, 16'h3400, 1'b0, 1'b0, 7);
    vt[3]  = mk(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
    vt[4]  = mk(16'h0000, 16'hC500, 1'b0, 16'hC500, 1'b0, 1'b0, 1);
    vt[5]  = mk(16'h0000, 16'hC500, 1'b1, 16'h4500, 1'b0, 1'b0, 1);
    vt[6]  = mk(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, 4);
    vt[7]  = mk(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b0, 1'b0, 4);
    vt[8]  = mk(16'h3800, 16'h3C00, 1'b0, 16'h3E00, 1'b0, 1'b0, 5);
    vt[9]  = mk(16'hC500, 16'h0000, 1'b0, 16'hC500, 1'b0, 1'b0, 1);
    vt[10] = mk(16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1);
    vt[11] = mk(16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 1);
    vt[12] = mk(16'h0600, 16'h0500, 1'b1, 16'h0000, 1'b0, 1'b1, 4);
    vt[13] = mk(16'h3C00, 16'hBC00, 1'b0, 16'h0000, 1'b0, 1'b0, 4);
    vt[14] = mk(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0, 6);

    rst_n = 1'b0;
    start = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 16'h0000);
    check("reset_flags", {ovf, unf}, 0);
    prev_res = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i], $sformatf("v%0d", i));
    end

    // reset while aligning: operation aborted, no done pulse
    @(negedge clk);
    drive(16'h3C00, 16'h3800, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_busy_in_align", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 16'h0000);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    prev_res = 16'h0000;

    // start held high with new operands while busy must be ignored
    @(negedge clk);
    drive(16'h3C00, 16'h3C00, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    drive(16'h7BFF, 16'h7BFF, 1'b0);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 64; c++) begin
      if (c >= 3) start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignore_done_seen", got, 1);
    check("ignore_latency", lat, 4);
    check("ignore_result", result, 16'h4000);
    check("ignore_ovf", ovf, 0);
    @(posedge clk); #1;
    check("ignore_idle", busy, 0);
    @(posedge clk); #1;
    check("ignore_result_held", result, 16'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
